dir_cmd_sequencer: RTL and testbench
====================================

// Module: dir_cmd_sequencer
// PURPOSE
//  Sequences the 3-bit drive command {dir, speed[1:0]} into dirctrl so that speed changes are never abrupt.
//  Accepts target commands over a valid/ready handshake and ramps one speed level per dwell period.
//  A direction reversal ramps to stop, holds stopped, then ramps up in the new direction.
//  A watchdog stops the drive if commands cease; estop forces an immediate stop.
// PARAMETERS
//  DWELL_CYCLES      1000    cycles between successive speed-level steps (>=1)
//  STOP_HOLD_CYCLES  2000    cycles held at speed 0 before a direction flip (>=1)
//  WDOG_CYCLES       100000  cycles without an accepted command before forced stop (>=1)
//  CNT_W             24      counter width; must hold the largest of the three above
// PORTS
//  clk           in   1  system clock
//  resetn        in   1  asynchronous active-low reset
//  cmd_valid     in   1  target command offered
//  cmd_target    in   3  target {dir, speed}; speed 0 = stop
//  cmd_ready     out  1  target accepted when cmd_valid & cmd_ready
//  estop         in   1  emergency stop, already synchronous to clk, level-sensitive
//  cmds          out  3  registered command to dirctrl
//  at_target     out  1  cmds equals latched target and no stop-hold is in progress
//  busy          out  1  ~at_target
//  wdog_expired  out  1  sticky; set on timeout, cleared by next accepted command
// BEHAVIOUR
//  Reset (async, immediate, any state): cmds=000, target=000, state STOPPED, counters 0, wdog_expired=0; outputs cmd_ready=1, at_target=1, busy=0.
//  cmd_ready = ~estop & (state != ESTOP), combinational; all other outputs are registered.
//  Accept: latch cmd_target; a target with speed 0 keeps current dir bit (normalised). Clear wdog counter and wdog_expired.
//  States: STOPPED, RAMP, HOLD_STOP, CRUISE, ESTOP.
//   STOPPED/CRUISE: on accept with target != cmds -> RAMP, dwell counter restarts at 0.
//   RAMP: dwell counter runs free; accepts do not restart it. On expiry (DWELL_CYCLES after start/last step):
//    same dir: speed steps one level toward target speed; reaching target -> CRUISE (STOPPED if speed 0).
//    dir differs, speed>0: speed steps down; reaching 0 -> HOLD_STOP.
//    step uses the newest target, including one accepted in the same cycle.
//   HOLD_STOP: entered at cycle T with speed 0. Always completes; at T+STOP_HOLD_CYCLES cmds <= {target dir, 00}.
//    Then target speed 0 -> STOPPED; else -> RAMP with the dwell counter restarted.
//   ESTOP: entered when estop=1 in any state; cmds <= 000 next cycle (no ramp), target <= 000.
//    Held while estop=1; on estop=0 -> STOPPED with cmds=000.
//  Latency: accept at cycle 0 -> first step visible on cmds at cycle DWELL_CYCLES.
//  Speed never changes by more than one level per step; dir bit changes only when speed=00.
//  Watchdog: counts while cmds speed != 0 or target speed != 0. On reaching WDOG_CYCLES:
//   wdog_expired <= 1, target <= {dir,00}, and the normal ramp-down follows.
//  Simultaneous events: estop beats accept; accept beats watchdog expiry (counter cleared).
//  Counters saturate and do not wrap.
// STRUCTURE
//  dir_ctrl_pkg: state enum, speed_t (2-bit levels 0..3 = 0/102/218/402), cmd_t struct {dir, speed},
//   function step_toward(cur, tgt).
//  One sub-module: dir_timer (loadable up-counter with expiry pulse), used for both dwell and stop-hold.
//   The watchdog counter is inline.
// TESTING  (DWELL=4, STOP_HOLD=6, WDOG=50; cycle 0 = accept cycle)
//  1 Reset: assert resetn=0 mid-ramp -> cmds=000, cmd_ready=1, at_target=1, wdog_expired=0 immediately.
//  2 Ramp up: accept 011 -> cmds 001@4, 010@8, 011@12; at_target=1 from cycle 12.
//  3 Reverse: from 011, accept 111 -> 010@4, 001@8, 000@12, 100@18, 101@22, 110@26, 111@30.
//    dirctrl outputs must never jump directly between -402 and +402.
//  4 Watchdog: accept 001 with no further commands -> 001@4, wdog_expired=1@50, cmds 000@54.
//    A new accept clears wdog_expired.
//  5 Estop: at cmds=010 raise estop at cycle k -> cmds=000@k+1, cmd_ready=0.
//    cmd_valid during estop is not accepted; estop low -> cmd_ready=1, state STOPPED.
//  6 Retarget mid-ramp: accept 011 @0; accept 000 @6 (cmds=001) -> cmds 000@8, then STOPPED, at_target=1.

Source files
------------

// File: rtl/dir_ctrl_pkg.sv
// =============================================================================
// Module   : dir_ctrl_pkg
// Brief    : Shared types and the speed-step helper for the drive command sequencer.
// Revision : 1.0
// =============================================================================
`default_nettype none

package dir_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_STOPPED   = 3'd0,
        ST_RAMP      = 3'd1,
        ST_HOLD_STOP = 3'd2,
        ST_CRUISE    = 3'd3,
        ST_ESTOP     = 3'd4
    } state_e;

    // Speed levels 0..3 map to drive magnitudes 0/102/218/402.
    typedef logic [1:0] speed_t;

    typedef struct packed {
        logic   dir;
        speed_t speed;
    } cmd_t;

    localparam speed_t c_SPEED_STOP = 2'd0;

    function automatic speed_t step_toward(input speed_t cur, input speed_t tgt);
        if (cur < tgt)
            return cur + 2'd1;
        else if (cur > tgt)
            return cur - 2'd1;
        else
            return cur;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dir_timer.sv
// =============================================================================
// Module   : dir_timer
// Brief    : Restartable saturating up-counter with a pulse on the last cycle of a period.
// Revision : 1.0
// =============================================================================
`default_nettype none

module dir_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_count <= '0;
        else if (i_load)
            r_count <= '0;
        else if (r_count != {CNT_W{1'b1}})
            r_count <= r_count + 1'b1;
    end

    // Period of i_limit cycles measured from the load edge.
    assign o_expired = (r_count == (i_limit - 1'b1));

endmodule

`default_nettype wire

// File: rtl/dir_cmd_sequencer.sv
// =============================================================================
// Module   : dir_cmd_sequencer
// Brief    : Ramps the {dir, speed} drive command toward a handshaked target, with watchdog and estop.
// Revision : 1.0
// =============================================================================
`default_nettype none

module dir_cmd_sequencer
    import dir_ctrl_pkg::*;
#(
    parameter int DWELL_CYCLES     = 1000,
    parameter int STOP_HOLD_CYCLES = 2000,
    parameter int WDOG_CYCLES      = 100000,
    parameter int CNT_W            = 24
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       cmd_valid,
    input  logic [2:0] cmd_target,
    output logic       cmd_ready,
    input  logic       estop,
    output logic [2:0] cmds,
    output logic       at_target,
    output logic       busy,
    output logic       wdog_expired
);

    localparam logic [CNT_W-1:0] c_dwell     = CNT_W'(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] c_hold      = CNT_W'(STOP_HOLD_CYCLES);
    localparam logic [CNT_W-1:0] c_wdog_max  = CNT_W'(WDOG_CYCLES);
    localparam logic [CNT_W-1:0] c_wdog_last = CNT_W'(WDOG_CYCLES - 1);

    state_e           r_state, w_state_nxt;
    cmd_t             r_cmds, w_cmds_nxt;
    cmd_t             r_target, w_target_nxt, w_target_eff, w_req;
    logic [CNT_W-1:0] r_wdog_cnt;
    logic             r_wdog_expired, r_at_target, r_busy;
    logic             w_accept, w_wdog_active, w_wdog_hit;
    logic             w_timer_load, w_timer_expired;
    logic [CNT_W-1:0] w_timer_limit;
    speed_t           w_step;

    assign cmd_ready     = ~estop & (r_state != ST_ESTOP);
    assign w_accept      = cmd_valid & cmd_ready;
    assign w_wdog_active = (r_cmds.speed != c_SPEED_STOP) || (r_target.speed != c_SPEED_STOP);
    assign w_wdog_hit    = w_wdog_active && (r_wdog_cnt == c_wdog_last) && !w_accept;
    assign w_timer_limit = (r_state == ST_HOLD_STOP) ? c_hold : c_dwell;

    dir_timer #(.CNT_W(CNT_W)) u_timer (
        .clk       (clk),
        .resetn    (resetn),
        .i_load    (w_timer_load),
        .i_limit   (w_timer_limit),
        .o_expired (w_timer_expired)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_cmds_nxt   = r_cmds;
        w_step       = r_cmds.speed;
        w_req        = cmd_t'(cmd_target);
        // A stop request keeps the direction currently being driven.
        if (w_req.speed == c_SPEED_STOP)
            w_req.dir = r_cmds.dir;
        if (w_accept)
            w_target_eff = w_req;
        else if (w_wdog_hit)
            w_target_eff = '{dir: r_cmds.dir, speed: c_SPEED_STOP};
        else
            w_target_eff = r_target;
        w_target_nxt = w_target_eff;

        if (estop) begin
            w_state_nxt  = ST_ESTOP;
            w_cmds_nxt   = '0;
            w_target_nxt = '0;
        end else begin
            case (r_state)
                ST_STOPPED, ST_CRUISE: begin
                    if (w_target_eff != r_cmds)
                        w_state_nxt = ST_RAMP;
                end
                ST_RAMP: begin
                    if (w_timer_expired) begin
                        if (w_target_eff.dir == r_cmds.dir) begin
                            w_step = step_toward(r_cmds.speed, w_target_eff.speed);
                            if (w_step == w_target_eff.speed)
                                w_state_nxt = (w_step == c_SPEED_STOP) ? ST_STOPPED : ST_CRUISE;
                        end else begin
                            // Reversal: only ever slow down; a flip needs a full stop-hold first.
                            if (r_cmds.speed != c_SPEED_STOP)
                                w_step = r_cmds.speed - 2'd1;
                            if (w_step == c_SPEED_STOP)
                                w_state_nxt = ST_HOLD_STOP;
                        end
                        w_cmds_nxt.speed = w_step;
                    end
                end
                ST_HOLD_STOP: begin
                    if (w_timer_expired) begin
                        w_cmds_nxt  = '{dir: w_target_eff.dir, speed: c_SPEED_STOP};
                        w_state_nxt = (w_target_eff.speed == c_SPEED_STOP) ? ST_STOPPED : ST_RAMP;
                    end
                end
                ST_ESTOP: begin
                    w_state_nxt = ST_STOPPED;
                    w_cmds_nxt  = '0;
                end
                default: begin
                    w_state_nxt = ST_STOPPED;
                    w_cmds_nxt  = '0;
                end
            endcase
        end

        w_timer_load = ((w_state_nxt != r_state) &&
                        ((w_state_nxt == ST_RAMP) || (w_state_nxt == ST_HOLD_STOP))) ||
                       ((r_state == ST_RAMP) && w_timer_expired);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state        <= ST_STOPPED;
            r_cmds         <= '0;
            r_target       <= '0;
            r_wdog_cnt     <= '0;
            r_wdog_expired <= 1'b0;
            r_at_target    <= 1'b1;
            r_busy         <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmds      <= w_cmds_nxt;
            r_target    <= w_target_nxt;
            r_at_target <= (w_cmds_nxt == w_target_nxt) && (w_state_nxt != ST_HOLD_STOP);
            r_busy      <= !((w_cmds_nxt == w_target_nxt) && (w_state_nxt != ST_HOLD_STOP));
            if (w_accept) begin
                r_wdog_cnt     <= '0;
                r_wdog_expired <= 1'b0;
            end else if (w_wdog_active && (r_wdog_cnt != c_wdog_max)) begin
                r_wdog_cnt <= r_wdog_cnt + 1'b1;
                if (w_wdog_hit)
                    r_wdog_expired <= 1'b1;
            end
        end
    end

    assign cmds         = r_cmds;
    assign at_target    = r_at_target;
    assign busy         = r_busy;
    assign wdog_expired = r_wdog_expired;

endmodule

`default_nettype wire

// File: tb/tb_dir_cmd_sequencer.sv
// =============================================================================
// Module   : tb_dir_cmd_sequencer
// Brief    : Self-checking bench: timestamp-based reference model plus directed timeline checks.
// Revision : 1.0
// =============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dir_cmd_sequencer;

    localparam int DW = 4;
    localparam int HD = 6;
    localparam int WD = 50;
    localparam int CW = 8;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_target = 3'b000;
    logic       estop = 1'b0;
    logic       cmd_ready, at_target, busy, wdog_expired;
    logic [2:0] cmds;

    always #5 clk = ~clk;

    dir_cmd_sequencer #(
        .DWELL_CYCLES     (DW),
        .STOP_HOLD_CYCLES (HD),
        .WDOG_CYCLES      (WD),
        .CNT_W            (CW)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .cmd_valid    (cmd_valid),
        .cmd_target   (cmd_target),
        .cmd_ready    (cmd_ready),
        .estop        (estop),
        .cmds         (cmds),
        .at_target    (at_target),
        .busy         (busy),
        .wdog_expired (wdog_expired)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: mode 0 settled, 1 ramping, 2 holding at stop, 3 emergency stopped.
    // Timing is kept as absolute cycle stamps of the next scheduled event.
    int m_mode, m_cdir, m_cspd, m_tdir, m_tspd, m_evt, m_wcnt;
    bit m_wexp;

    always @(posedge clk) begin
        bit ready, acc, active, hit;
        cyc = cyc + 1;
        if (!resetn) begin
            m_mode = 0; m_cdir = 0; m_cspd = 0; m_tdir = 0; m_tspd = 0;
            m_evt = 0; m_wcnt = 0; m_wexp = 0;
        end else begin
            ready  = !estop && (m_mode != 3);
            acc    = cmd_valid && ready;
            active = (m_cspd != 0) || (m_tspd != 0);
            hit    = 0;
            if (acc) begin
                m_wcnt = 0; m_wexp = 0;
            end else if (active && m_wcnt < WD) begin
                m_wcnt++;
                if (m_wcnt == WD) begin m_wexp = 1; hit = 1; end
            end
            if (estop) begin
                m_mode = 3; m_cdir = 0; m_cspd = 0; m_tdir = 0; m_tspd = 0;
            end else if (m_mode == 3) begin
                m_mode = 0; m_cdir = 0; m_cspd = 0;
            end else begin
                if (acc) begin
                    m_tspd = int'(cmd_target[1:0]);
                    m_tdir = (m_tspd == 0) ? m_cdir : int'(cmd_target[2]);
                end else if (hit) begin
                    m_tspd = 0; m_tdir = m_cdir;
                end
                case (m_mode)
                    0: if (m_tdir != m_cdir || m_tspd != m_cspd) begin
                        m_mode = 1; m_evt = cyc + DW;
                    end
                    1: if (cyc == m_evt) begin
                        if (m_tdir == m_cdir) begin
                            m_cspd += (m_tspd > m_cspd) ? 1 : ((m_tspd < m_cspd) ? -1 : 0);
                            if (m_cspd == m_tspd) m_mode = 0;
                            else m_evt = cyc + DW;
                        end else begin
                            if (m_cspd > 0) m_cspd--;
                            if (m_cspd == 0) begin m_mode = 2; m_evt = cyc + HD; end
                            else m_evt = cyc + DW;
                        end
                    end
                    2: if (cyc == m_evt) begin
                        m_cdir = m_tdir;
                        if (m_tspd == 0) m_mode = 0;
                        else begin m_mode = 1; m_evt = cyc + DW; end
                    end
                    default: m_mode = 0;
                endcase
            end
        end
    end

    // Cycle-by-cycle comparison against the model, plus the no-jump safety property.
    int prev_cmds = -1;
    always @(negedge clk) begin
        int exp_cmds, exp_at, pd, pc;
        if (!resetn) begin
            prev_cmds = -1;
        end else if (check_en) begin
            exp_cmds = m_cdir * 4 + m_cspd;
            exp_at   = (m_cdir == m_tdir && m_cspd == m_tspd && m_mode != 2) ? 1 : 0;
            chk("cmds", int'(cmds), exp_cmds);
            chk("cmd_ready", int'(cmd_ready), (!estop && m_mode != 3) ? 1 : 0);
            chk("at_target", int'(at_target), exp_at);
            chk("busy", int'(busy), 1 - exp_at);
            chk("wdog_expired", int'(wdog_expired), int'(m_wexp));
            if (prev_cmds >= 0 && !estop && m_mode != 3) begin
                pd = prev_cmds[1:0]; pc = int'(cmds[1:0]);
                chk("no_jump",
                    ((pc - pd <= 1) && (pd - pc <= 1) &&
                     (prev_cmds[2] == cmds[2] || (pd == 0 && pc == 0))) ? 1 : 0, 1);
            end
            prev_cmds = int'(cmds);
        end
    end

    task automatic send(input logic [2:0] c, output int t);
        cmd_valid  = 1'b1;
        cmd_target = c;
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
        t = cyc;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic expect_cmds(input string name, input int t, input logic [2:0] exp);
        wait_cyc(t);
        chk(name, int'(cmds), int'(exp));
    endtask

    initial begin
        int t0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmds", int'(cmds), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_at_target", int'(at_target), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_wdog", int'(wdog_expired), 0);
        resetn   = 1'b1;
        check_en = 1'b1;

        // Ramp up
        send(3'b011, t0);
        expect_cmds("up_4", t0 + 4, 3'b001);
        expect_cmds("up_8", t0 + 8, 3'b010);
        expect_cmds("up_12", t0 + 12, 3'b011);
        chk("up_at_target", int'(at_target), 1);

        // Reversal through a stop-hold
        send(3'b111, t0);
        expect_cmds("rev_4", t0 + 4, 3'b010);
        expect_cmds("rev_8", t0 + 8, 3'b001);
        expect_cmds("rev_12", t0 + 12, 3'b000);
        wait_cyc(t0 + 14);
        chk("rev_hold_at_target", int'(at_target), 0);
        expect_cmds("rev_17", t0 + 17, 3'b000);
        expect_cmds("rev_18", t0 + 18, 3'b100);
        expect_cmds("rev_22", t0 + 22, 3'b101);
        expect_cmds("rev_26", t0 + 26, 3'b110);
        expect_cmds("rev_30", t0 + 30, 3'b111);
        chk("rev_at_target", int'(at_target), 1);

        // Emergency stop
        @(posedge clk); #1;
        estop = 1'b1;
        t0 = cyc;
        #1;
        chk("estop_ready", int'(cmd_ready), 0);
        expect_cmds("estop_k1", t0 + 1, 3'b000);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_target = 3'b011;
        repeat (3) @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        estop = 1'b0;
        @(posedge clk); #1;
        chk("estop_rel_ready", int'(cmd_ready), 1);
        chk("estop_rel_cmds", int'(cmds), 0);
        chk("estop_rel_at_target", int'(at_target), 1);

        // Watchdog
        send(3'b001, t0);
        expect_cmds("wd_4", t0 + 4, 3'b001);
        wait_cyc(t0 + 49);
        chk("wd_49", int'(wdog_expired), 0);
        wait_cyc(t0 + 50);
        chk("wd_50", int'(wdog_expired), 1);
        expect_cmds("wd_53", t0 + 53, 3'b001);
        expect_cmds("wd_54", t0 + 54, 3'b000);
        @(posedge clk); #1;
        send(3'b000, t0);
        chk("wd_clear", int'(wdog_expired), 0);

        // Retarget mid-ramp
        send(3'b011, t0);
        expect_cmds("rt_5", t0 + 5, 3'b001);
        cmd_valid = 1'b1; cmd_target = 3'b000;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        expect_cmds("rt_7", t0 + 7, 3'b001);
        expect_cmds("rt_8", t0 + 8, 3'b000);
        chk("rt_at_target", int'(at_target), 1);

        // Asynchronous reset mid-ramp
        send(3'b011, t0);
        expect_cmds("ar_5", t0 + 5, 3'b001);
        #2;
        resetn = 1'b0;
        #1;
        chk("ar_cmds", int'(cmds), 0);
        chk("ar_ready", int'(cmd_ready), 1);
        chk("ar_at_target", int'(at_target), 1);
        chk("ar_wdog", int'(wdog_expired), 0);
        @(posedge clk); #1;
        resetn = 1'b1;

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            cmd_valid  = ($urandom_range(0, 15) == 0);
            cmd_target = 3'($urandom);
            if (estop) estop = ($urandom_range(0, 3) != 0);
            else       estop = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 149) == 0) begin
                cmd_valid = 1'b0;
                for (int j = 0; j < 80; j++) begin
                    @(posedge clk); #1;
                end
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        estop = 1'b0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

endmodule

`default_nettype wire
